// File: rtl/gbf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gbf_pkg
// Description : Shared FSM encoding, buffer selectors and width defaults for
//               the GBF loader.
// Revision    : 1.0 - initial release
// ============================================================================
package gbf_pkg;

  localparam int C_GBF_DATA_BITWIDTH = 512;
  localparam int C_GBF_ADDR_BITWIDTH = 5;
  localparam int C_GBF_DEPTH         = 32;

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_FILL1 = 2'd1;
  localparam logic [1:0] C_ST_FILL2 = 2'd2;
  localparam logic [1:0] C_ST_WAIT  = 2'd3;

  localparam logic C_BUF1 = 1'b0;
  localparam logic C_BUF2 = 1'b1;

endpackage : gbf_pkg
`default_nettype wire

// File: rtl/gbf_wr_port.sv
`default_nettype none
// ============================================================================
// Module      : gbf_wr_port
// Description : Registered port-A write stage (en/we/addr/w_data) of one GBF.
// Revision    : 1.0 - initial release
// ============================================================================
module gbf_wr_port #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_en,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_w_data
);

  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_take;

  assign w_take = i_wr_req & ~i_flush;

  // Address and data hold their last value between writes.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_en <= w_take;
      if (w_take) begin
        r_addr <= i_wr_addr;
        r_data <= i_wr_data;
      end
    end
  end

  assign o_en     = r_en;
  assign o_we     = r_en;
  assign o_addr   = r_addr;
  assign o_w_data = r_data;

endmodule : gbf_wr_port
`default_nettype wire

// File: rtl/gbf_loader.sv
`default_nettype none
// ============================================================================
// Module      : gbf_loader
// Description : Streams source words into the ping-pong GBF pair, tracks tile
//               readiness and refills buffers on accelerator release.
// Revision    : 1.0 - initial release
// ============================================================================
module gbf_loader
  import gbf_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = C_GBF_DATA_BITWIDTH,
  parameter int GBF_ADDR_BITWIDTH = C_GBF_ADDR_BITWIDTH,
  parameter int GBF_DEPTH         = C_GBF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [GBF_ADDR_BITWIDTH:0]   tile_words,
  input  logic                         finish,
  input  logic                         src_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] src_data,
  output logic                         src_ready,
  output logic                         en1a,
  output logic                         we1a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
  output logic                         en2a,
  output logic                         we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
  output logic                         buf1_ready,
  output logic                         buf2_ready,
  output logic                         data_avail,
  input  logic                         gbf1_need_data,
  input  logic                         gbf2_need_data,
  output logic                         cfg_err
);

  localparam int                 C_CNT_W = GBF_ADDR_BITWIDTH + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(GBF_DEPTH);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] r_tile_len;
  logic               r_next_buf;
  logic               r_ready1;
  logic               r_ready2;
  logic               r_pend1;
  logic               r_pend2;
  logic               r_avail;
  logic               r_cfg_err;

  logic w_wr_req1;
  logic w_wr_req2;
  logic w_hs;
  logic w_last;
  logic w_tw_ok;
  logic w_start_ok;
  logic w_occ1;
  logic w_occ2;

  assign w_tw_ok    = (tile_words != '0) && (tile_words <= C_DEPTH);
  assign w_start_ok = (r_state == C_ST_IDLE) && start && w_tw_ok;
  assign w_hs       = w_wr_req1 | w_wr_req2;
  assign w_last     = w_hs && (r_cnt == (r_tile_len - 1'b1));

  // A tile whose last write is still committing counts as occupied, so a
  // one-word tile in the other buffer can never overwrite it.
  assign w_occ1 = r_ready1 | r_pend1;
  assign w_occ2 = r_ready2 | r_pend2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (finish) begin
      w_state_nxt = C_ST_IDLE;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (w_start_ok) w_state_nxt = C_ST_FILL1;
        end
        C_ST_FILL1: begin
          if (w_last) w_state_nxt = w_occ2 ? C_ST_WAIT : C_ST_FILL2;
        end
        C_ST_FILL2: begin
          if (w_last) w_state_nxt = w_occ1 ? C_ST_WAIT : C_ST_FILL1;
        end
        C_ST_WAIT: begin
          if (r_next_buf == C_BUF1) begin
            if (!w_occ1) w_state_nxt = C_ST_FILL1;
          end else begin
            if (!w_occ2) w_state_nxt = C_ST_FILL2;
          end
        end
        default: w_state_nxt = C_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    src_ready = 1'b0;
    w_wr_req1 = 1'b0;
    w_wr_req2 = 1'b0;
    case (r_state)
      C_ST_FILL1: begin
        src_ready = 1'b1;
        w_wr_req1 = src_valid;
      end
      C_ST_FILL2: begin
        src_ready = 1'b1;
        w_wr_req2 = src_valid;
      end
      default: begin
        src_ready = 1'b0;
      end
    endcase
  end

  // Ready rises one edge after the last beat, when that write commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_tile_len <= '0;
      r_next_buf <= C_BUF1;
      r_ready1   <= 1'b0;
      r_ready2   <= 1'b0;
      r_pend1    <= 1'b0;
      r_pend2    <= 1'b0;
      r_avail    <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else if (finish) begin
      r_cnt      <= '0;
      r_next_buf <= C_BUF1;
      r_ready1   <= 1'b0;
      r_ready2   <= 1'b0;
      r_pend1    <= 1'b0;
      r_pend2    <= 1'b0;
      r_avail    <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == C_ST_IDLE) && start && !w_tw_ok;
      if (w_start_ok) begin
        r_tile_len <= tile_words;
        r_cnt      <= '0;
        r_next_buf <= C_BUF1;
      end
      if (w_hs) begin
        if (w_last) begin
          r_cnt      <= '0;
          r_next_buf <= ~r_next_buf;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      r_pend1 <= w_last & w_wr_req1;
      r_pend2 <= w_last & w_wr_req2;
      if (r_pend1) begin
        r_ready1 <= 1'b1;
      end else if (gbf1_need_data) begin
        r_ready1 <= 1'b0;
      end
      if (r_pend2) begin
        r_ready2 <= 1'b1;
      end else if (gbf2_need_data) begin
        r_ready2 <= 1'b0;
      end
      if (r_pend1 | r_pend2) r_avail <= 1'b1;
    end
  end

  gbf_wr_port #(
    .DATA_W (GBF_DATA_BITWIDTH),
    .ADDR_W (GBF_ADDR_BITWIDTH)
  ) u_wr_port1 (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_flush   (finish),
    .i_wr_req  (w_wr_req1),
    .i_wr_addr (r_cnt[GBF_ADDR_BITWIDTH-1:0]),
    .i_wr_data (src_data),
    .o_en      (en1a),
    .o_we      (we1a),
    .o_addr    (addr1a),
    .o_w_data  (w_data1a)
  );

  gbf_wr_port #(
    .DATA_W (GBF_DATA_BITWIDTH),
    .ADDR_W (GBF_ADDR_BITWIDTH)
  ) u_wr_port2 (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_flush   (finish),
    .i_wr_req  (w_wr_req2),
    .i_wr_addr (r_cnt[GBF_ADDR_BITWIDTH-1:0]),
    .i_wr_data (src_data),
    .o_en      (en2a),
    .o_we      (we2a),
    .o_addr    (addr2a),
    .o_w_data  (w_data2a)
  );

  assign buf1_ready = r_ready1;
  assign buf2_ready = r_ready2;
  assign data_avail = r_avail;
  assign cfg_err    = r_cfg_err;

endmodule : gbf_loader
`default_nettype wire

// File: tb/tb_gbf_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gbf_loader
// Description : Self-checking bench for gbf_loader: tile-level reference model
//               plus shadow GBF contents, directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gbf_loader;

  localparam int DW    = 512;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   tile_words;
  logic          finish;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          en1a, we1a, en2a, we2a;
  logic [AW-1:0] addr1a, addr2a;
  logic [DW-1:0] w_data1a, w_data2a;
  logic          buf1_ready, buf2_ready, data_avail, cfg_err;
  logic          gbf1_need_data, gbf2_need_data;

  always #5 clk = ~clk;

  gbf_loader #(
    .GBF_DATA_BITWIDTH (DW),
    .GBF_ADDR_BITWIDTH (AW),
    .GBF_DEPTH         (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .tile_words     (tile_words),
    .finish         (finish),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .en1a           (en1a),
    .we1a           (we1a),
    .addr1a         (addr1a),
    .w_data1a       (w_data1a),
    .en2a           (en2a),
    .we2a           (we2a),
    .addr2a         (addr2a),
    .w_data2a       (w_data2a),
    .buf1_ready     (buf1_ready),
    .buf2_ready     (buf2_ready),
    .data_avail     (data_avail),
    .gbf1_need_data (gbf1_need_data),
    .gbf2_need_data (gbf2_need_data),
    .cfg_err        (cfg_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 = idle, 1 = filling m_buf, 2 = waiting for m_buf.
  int            m_mode, m_buf, m_cnt, m_tlen;
  bit            m_rdy[2], m_pnd[2], m_chk[2], m_en[2];
  bit            m_avail, m_cfg;
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];
  logic [DW-1:0] tile0[$], tile1[$];
  logic [DW-1:0] sh0[DEPTH], sh1[DEPTH];
  int            shw[2];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_buf = 0; m_cnt = 0; m_tlen = 0;
    m_avail = 0; m_cfg = 0;
    for (int b = 0; b < 2; b++) begin
      m_rdy[b] = 0; m_pnd[b] = 0; m_chk[b] = 0; m_en[b] = 0;
      m_addr[b] = '0; m_data[b] = '0; shw[b] = 0;
    end
    tile0.delete(); tile1.delete();
  endtask

  task automatic begin_fill(input int b);
    m_mode = 1;
    if (b == 0) tile0.delete(); else tile1.delete();
    shw[b] = 0;
  endtask

  task automatic model_edge();
    bit o_rdy[2];
    bit o_pnd[2];
    bit need;
    o_rdy = m_rdy;
    o_pnd = m_pnd;
    if (finish) begin
      m_mode = 0; m_cnt = 0; m_buf = 0; m_avail = 0; m_cfg = 0;
      for (int b = 0; b < 2; b++) begin
        m_rdy[b] = 0; m_pnd[b] = 0; m_chk[b] = 0; m_en[b] = 0;
      end
      return;
    end
    m_cfg = 0;
    m_en[0] = 0; m_en[1] = 0;
    for (int b = 0; b < 2; b++) begin
      need = (b == 0) ? gbf1_need_data : gbf2_need_data;
      if (o_pnd[b]) begin
        m_rdy[b] = 1; m_avail = 1; m_pnd[b] = 0; m_chk[b] = 1;
      end else if (need && o_rdy[b]) begin
        m_rdy[b] = 0;
      end
    end
    case (m_mode)
      0: if (start) begin
        if (tile_words >= 1 && tile_words <= DEPTH) begin
          m_tlen = int'(tile_words); m_cnt = 0; m_buf = 0;
          begin_fill(0);
        end else begin
          m_cfg = 1;
        end
      end
      1: if (src_valid) begin
        m_en[m_buf] = 1;
        m_addr[m_buf] = AW'(m_cnt);
        m_data[m_buf] = src_data;
        if (m_buf == 0) tile0.push_back(src_data); else tile1.push_back(src_data);
        if (m_cnt == m_tlen - 1) begin
          m_cnt = 0;
          m_pnd[m_buf] = 1;
          m_buf = 1 - m_buf;
          if (o_rdy[m_buf] || o_pnd[m_buf]) m_mode = 2;
          else begin_fill(m_buf);
        end else begin
          m_cnt++;
        end
      end
      default: if (!(o_rdy[m_buf] || o_pnd[m_buf])) begin_fill(m_buf);
    endcase
  endtask

  task automatic compare();
    chk("src_ready", src_ready, m_mode == 1);
    chk("en1a", en1a, m_en[0]);
    chk("we1a", we1a, m_en[0]);
    chk("addr1a", addr1a, m_addr[0]);
    chk("w_data1a", w_data1a, m_data[0]);
    chk("en2a", en2a, m_en[1]);
    chk("we2a", we2a, m_en[1]);
    chk("addr2a", addr2a, m_addr[1]);
    chk("w_data2a", w_data2a, m_data[1]);
    chk("buf1_ready", buf1_ready, m_rdy[0]);
    chk("buf2_ready", buf2_ready, m_rdy[1]);
    chk("data_avail", data_avail, m_avail);
    chk("cfg_err", cfg_err, m_cfg);
    if (en1a && we1a) begin sh0[addr1a] = w_data1a; shw[0]++; end
    if (en2a && we2a) begin sh1[addr2a] = w_data2a; shw[1]++; end
    if (m_chk[0]) begin
      m_chk[0] = 0;
      chk("tile1_writes", shw[0], tile0.size());
      for (int i = 0; i < tile0.size(); i++) chk("tile1_word", sh0[i], tile0[i]);
    end
    if (m_chk[1]) begin
      m_chk[1] = 0;
      chk("tile2_writes", shw[1], tile1.size());
      for (int i = 0; i < tile1.size(); i++) chk("tile2_word", sh1[i], tile1[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset = 1'b0; start = 0; tile_words = '0; finish = 0;
    src_valid = 0; src_data = '0; gbf1_need_data = 0; gbf2_need_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_en1a", en1a, 0);
    chk("rst_addr1a", addr1a, 0);
    chk("rst_buf1_ready", buf1_ready, 0);
    chk("rst_data_avail", data_avail, 0);
    compare();
    reset = 1'b1;

    // First two tiles, four words each, data 0..7.
    start = 1; tile_words = 4; cyc(); start = 0;
    chk("fill1_src_ready", src_ready, 1);
    for (int i = 0; i < 8; i++) begin
      src_valid = 1; src_data = DW'(i); cyc();
      if (i < 4) begin
        chk("lit_en1a", en1a, 1); chk("lit_addr1a", addr1a, i); chk("lit_data1a", w_data1a, i);
      end else begin
        chk("lit_en2a", en2a, 1); chk("lit_addr2a", addr2a, i - 4); chk("lit_data2a", w_data2a, i);
      end
      if (i == 4) begin
        chk("lit_buf1_ready", buf1_ready, 1); chk("lit_data_avail", data_avail, 1);
      end
    end
    chk("lit_wait_src_ready", src_ready, 0);
    src_data = DW'(8); cyc();
    chk("lit_buf2_ready", buf2_ready, 1);
    gbf1_need_data = 1; cyc(); gbf1_need_data = 0;
    chk("lit_release1", buf1_ready, 0);
    cyc();
    chk("lit_refill_src_ready", src_ready, 1);
    for (int i = 0; i < 4; i++) begin
      src_data = DW'(8 + i); cyc();
      chk("lit_refill_addr1a", addr1a, i);
    end
    src_valid = 0; cyc();
    chk("lit_refill_buf1_ready", buf1_ready, 1);

    // Release buffer2, then request it again while it is mid-fill.
    gbf2_need_data = 1; cyc(); gbf2_need_data = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      src_valid = 1; src_data = DW'(12 + i);
      gbf2_need_data = (i == 2);
      cyc();
      gbf2_need_data = 0;
      if (i == 2) chk("lit_early_release_ignored", buf2_ready, 0);
    end
    src_valid = 0; cyc();
    chk("lit_buf2_ready_after_fill", buf2_ready, 1);

    // Abort after word 1 of buffer1, then restart from address 0.
    finish = 1; cyc(); finish = 0;
    start = 1; tile_words = 4; cyc(); start = 0;
    for (int i = 0; i < 2; i++) begin src_valid = 1; src_data = rnd_word(); cyc(); end
    src_valid = 0; finish = 1; cyc(); finish = 0;
    chk("lit_fin_buf1", buf1_ready, 0);
    chk("lit_fin_buf2", buf2_ready, 0);
    chk("lit_fin_avail", data_avail, 0);
    chk("lit_fin_src_ready", src_ready, 0);
    start = 1; tile_words = 4; cyc(); start = 0;
    src_valid = 1; src_data = rnd_word(); cyc(); src_valid = 0;
    chk("lit_restart_en1a", en1a, 1);
    chk("lit_restart_addr1a", addr1a, 0);
    finish = 1; cyc(); finish = 0;

    // Illegal tile sizes.
    start = 1; tile_words = 0; cyc(); start = 0;
    chk("lit_cfg_err_0", cfg_err, 1);
    cyc();
    chk("lit_cfg_err_pulse", cfg_err, 0);
    start = 1; tile_words = 33; cyc(); start = 0;
    chk("lit_cfg_err_33", cfg_err, 1);
    chk("lit_cfg_idle", src_ready, 0);
    cyc();

    // Full-depth tile with gaps in src_valid.
    start = 1; tile_words = 32; cyc(); start = 0;
    for (int k = 0; k < 400 && !buf1_ready; k++) begin
      src_valid = ($urandom_range(2) != 0); src_data = rnd_word(); cyc();
    end
    src_valid = 0;
    chk("tile32_ready", buf1_ready, 1);
    chk("tile32_writes", shw[0], 32);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      finish = ($urandom_range(199) == 0);
      start = ($urandom_range(3) == 0);
      if ($urandom_range(4) == 0) tile_words = ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom_range(63, 33));
      else tile_words = 6'($urandom_range(32, 2));
      src_valid = ($urandom_range(3) != 0);
      src_data = rnd_word();
      gbf1_need_data = ($urandom_range(7) == 0);
      gbf2_need_data = ($urandom_range(7) == 0);
      cyc();
    end
    finish = 0; start = 0; src_valid = 0; gbf1_need_data = 0; gbf2_need_data = 0;

    // Asynchronous reset in the middle of a fill.
    finish = 1; cyc(); finish = 0;
    start = 1; tile_words = 8; cyc(); start = 0;
    for (int i = 0; i < 3; i++) begin src_valid = 1; src_data = rnd_word(); cyc(); end
    #2 reset = 1'b0;
    #1;
    chk("arst_en1a", en1a, 0);
    chk("arst_addr1a", addr1a, 0);
    chk("arst_w_data1a", w_data1a, 0);
    chk("arst_src_ready", src_ready, 0);
    chk("arst_data_avail", data_avail, 0);
    model_reset();
    @(negedge clk);
    compare();
    reset = 1'b1; src_valid = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_gbf_loader
`default_nettype wire

// File: doc/gbf_loader.md
Name: gbf_loader

Overview:
- Producer side of the activation/weight global-buffer (GBF) write interface of accelerator_w_o_sram.
- Accepts a stream of GBF-wide words from the off-chip/DMA side and writes each tile into the ping-pong GBF pair through port A (en/we/addr/w_data).
- Raises buf1_ready/buf2_ready and data_avail toward the accelerator, and refills a buffer when the accelerator raises the matching need_data.
- One instance per data type (actv, wgt).

Parameters:
- GBF_DATA_BITWIDTH, 512, width of one GBF word.
- GBF_ADDR_BITWIDTH, 5, GBF address width.
- GBF_DEPTH, 32, words per buffer; must equal 2**GBF_ADDR_BITWIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins loading; samples tile_words.
- tile_words  input  GBF_ADDR_BITWIDTH+1  words per tile, legal range 1..GBF_DEPTH.
- finish  input  1  one-cycle pulse; aborts and returns to IDLE.
- src_valid  input  1  source word valid.
- src_data  input  GBF_DATA_BITWIDTH  source word.
- src_ready  output  1  loader accepts src_data this cycle.
- en1a, we1a  output  1  buffer1 port-A enable/write.
- addr1a  output  GBF_ADDR_BITWIDTH  buffer1 write address.
- w_data1a  output  GBF_DATA_BITWIDTH  buffer1 write data.
- en2a, we2a, addr2a, w_data2a  output  same as buffer1  buffer2 port A.
- buf1_ready, buf2_ready  output  1  buffer holds a complete tile.
- data_avail  output  1  at least one tile delivered since start.
- gbf1_need_data, gbf2_need_data  input  1  accelerator releases buffer N.
- cfg_err  output  1  one-cycle pulse: start rejected.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; word counter 0; next buffer = 1; tile_len register 0.
- FSM states: IDLE, FILL1, FILL2, WAIT.
- IDLE:
  - start with 1<=tile_words<=GBF_DEPTH: latch tile_len, go to FILL1.
  - start with an illegal tile_words: cfg_err=1 for one cycle, stay in IDLE.
- FILLn:
  - src_ready=1 combinationally.
  - Each handshake (src_valid & src_ready) at edge t registers enN=weN=1, addrNa=counter, w_dataNa=src_data for exactly one cycle; the write commits at edge t+1. Write latency is 1.
  - No handshake: enN=weN=0; addr and data hold their last value.
  - Counter increments per handshake.
  - On the beat where counter==tile_len-1: counter clears to 0, next buffer toggles, and state moves to FILL(other) if that buffer's ready=0, else to WAIT.
  - bufN_ready rises at edge t+1, in the same cycle the last write commits, so the accelerator can read from the following cycle.
- WAIT:
  - src_ready=0.
  - Go to FILL(next buffer) on the cycle after that buffer's ready is 0.
- Release:
  - gbfN_need_data=1 while bufN_ready=1 clears bufN_ready at the next edge.
  - need_data while ready=0 is ignored. This covers a buffer still filling: no early release.
  - Release and last write of the other buffer in the same cycle: both take effect independently.
- Fill order is strictly alternating 1,2,1,2, even if the buffers are released out of order.
- data_avail: set with the first bufN_ready rise after start; cleared only by finish or reset.
- finish (any state, priority over start and handshakes):
  - Next edge: IDLE, counter 0, next buffer=1, both ready=0, data_avail=0, en/we=0.
  - A partially written tile is discarded. The accelerator treats the GBFs as empty.
- start outside IDLE is ignored.
- Counter width is GBF_ADDR_BITWIDTH+1. addr is the counter's low bits; tile_len=GBF_DEPTH reaches address GBF_DEPTH-1 with no wrap.

Decomposition:
- Shared package gbf_pkg:
  - FSM state encoding (IDLE=2'd0, FILL1=2'd1, FILL2=2'd2, WAIT=2'd3).
  - Buffer-select constants BUF1=1'b0, BUF2=1'b1.
  - GBF width defaults.
- One natural sub-module, gbf_wr_port: the registered en/we/addr/w_data stage, instantiated twice (buffer1, buffer2).
- The FSM, counter and ready flags stay in gbf_loader.

Test Plan:
- Reset then start with tile_words=4 and src_valid held high with data 0..3: en1a/we1a pulse on 4 consecutive cycles with addr1a=0,1,2,3 and matching data; buf1_ready=1 and data_avail=1 in the cycle after the last write; loader moves to FILL2 and writes words 4..7 to buffer2 at addr 0..3.
- With both buffers full: src_ready=0 (WAIT). Pulse gbf1_need_data: buf1_ready=0 next cycle; the next 4 words go to buffer1, then buf1_ready=1 again.
- tile_words=32 with gaps in src_valid: exactly 32 writes to addr 0..31; no write in idle-valid cycles; no address wrap.
- gbf2_need_data asserted while buffer2 is mid-fill (word 2 of 4): ignored; buf2_ready rises normally after word 3.
- finish after word 1 of buffer1: next cycle both ready=0, data_avail=0, src_ready=0; a new start refills buffer1 from addr 0.
- start with tile_words=0 and with tile_words=33: cfg_err pulses for 1 cycle, state stays IDLE, no writes. Async reset asserted mid-fill clears all outputs immediately.
